// File: rtl/ov7670_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// ov7670_cfg_sequencer_if
//
// Write channel between the configuration sequencer and the SCCB master.
// A request is a valid/ready transfer of one (register, value) pair. The
// SCCB master later answers it with a one-cycle done or nack pulse.
//
// Signals:
//   wr_valid  sequencer -> SCCB   write request pending
//   wr_ready  SCCB -> sequencer   request accepted this cycle
//   wr_reg    sequencer -> SCCB   register address (REG_W bits)
//   wr_val    sequencer -> SCCB   register value   (REG_W bits)
//   wr_done   SCCB -> sequencer   one-cycle pulse: transaction acknowledged
//   wr_nack   SCCB -> sequencer   one-cycle pulse: transaction not acknowledged
//
// Modports: master (sequencer side), slave (SCCB master side).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface ov7670_cfg_sequencer_if #(
    parameter int REG_W = 8
) ();
    logic             wr_valid;
    logic             wr_ready;
    logic [REG_W-1:0] wr_reg;
    logic [REG_W-1:0] wr_val;
    logic             wr_done;
    logic             wr_nack;

    modport master (
        output wr_valid, wr_reg, wr_val,
        input  wr_ready, wr_done, wr_nack
    );

    modport slave (
        input  wr_valid, wr_reg, wr_val,
        output wr_ready, wr_done, wr_nack
    );
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// ov7670_cfg_sequencer
//
// Walks a register table held in a registered config ROM and turns each entry
// into a write on the SCCB master. The table is split into 2^BANK_W profile
// banks of 2^ADDR_W entries. Each entry is {register, value}. Two codes are
// reserved: END_CODE ends the table and DELAY_CODE waits DELAY_CYCLES clocks.
// A nacked write is re-issued up to MAX_RETRY times before the sequence fails.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse; starts a sequence when not busy
//   bank         profile select, sampled on an accepted start
//   rom_en       ROM read enable, high for one cycle per fetch
//   rom_addr     ROM address {bank, index}; holds its last value
//   rom_data     ROM output, valid the cycle after rom_en
//   sccb         write channel to the SCCB master (master modport)
//   busy         sequence in progress
//   done         sequence completed; held until the next accepted start
//   error        retries exhausted; held until the next accepted start
//   err_index    table index of the failing entry
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ov7670_cfg_sequencer #(
    parameter int                ADDR_W       = 8,
    parameter int                BANK_W       = 2,
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-1:0] END_CODE     = 16'hFFFF,
    parameter logic [DATA_W-1:0] DELAY_CODE   = 16'hFFF0,
    parameter int                DELAY_CYCLES = 250000,
    parameter int                MAX_RETRY    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BANK_W-1:0]        bank,
    output logic                     rom_en,
    output logic [BANK_W+ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    ov7670_cfg_sequencer_if.master   sccb,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDR_W-1:0]        err_index
);

    localparam int CNT_W   = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, DELAY, ADVANCE, FINISH, FAIL
    } state_e;

    state_e              state;
    state_e              state_next;
    logic [BANK_W-1:0]   bank_q;
    logic [ADDR_W-1:0]   index;
    logic [ADDR_W-1:0]   index_inc;
    logic [DATA_W-1:0]   entry_q;
    logic [RETRY_W-1:0]  retry;
    logic [CNT_W-1:0]    delay_cnt;
    logic [ADDR_W-1:0]   err_index_q;
    logic [BANK_W+ADDR_W-1:0] rom_addr_q;
    logic                resting;

    // FINISH and FAIL behave like IDLE: they accept a new start.
    assign resting   = (state == IDLE) || (state == FINISH) || (state == FAIL);
    assign index_inc = index + ADDR_W'(1);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FINISH, FAIL: if (start) state_next = FETCH;
            FETCH:              state_next = DECODE;
            DECODE: begin
                if (rom_data == END_CODE)        state_next = FINISH;
                else if (rom_data == DELAY_CODE) state_next = DELAY;
                else                             state_next = ISSUE;
            end
            ISSUE:    if (sccb.wr_ready) state_next = WAIT_ACK;
            WAIT_ACK: begin
                // A nack wins over a done in the same cycle.
                if (sccb.wr_nack)
                    state_next = (retry == RETRY_W'(MAX_RETRY)) ? FAIL : ISSUE;
                else if (sccb.wr_done)
                    state_next = ADVANCE;
            end
            DELAY:    if (delay_cnt == '0) state_next = ADVANCE;
            // The last index of a bank ends the table even without END_CODE.
            ADVANCE:  state_next = (index == '1) ? FINISH : FETCH;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs decoded from state. They follow reset asynchronously, so
    // wr_valid drops as soon as rst_n falls.
    always_comb begin
        rom_en        = (state == FETCH);
        sccb.wr_valid = (state == ISSUE);
        busy          = !resting;
        done          = (state == FINISH);
        error         = (state == FAIL);
    end

    assign sccb.wr_reg = entry_q[DATA_W-1:DATA_W/2];
    assign sccb.wr_val = entry_q[DATA_W/2-1:0];
    assign rom_addr    = rom_addr_q;
    assign err_index   = err_index_q;

    // Datapath: bank, index, entry, retry and delay counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q      <= '0;
            index       <= '0;
            entry_q     <= '0;
            retry       <= '0;
            delay_cnt   <= '0;
            err_index_q <= '0;
            rom_addr_q  <= '0;
        end else begin
            case (state)
                IDLE, FINISH, FAIL: begin
                    if (start) begin
                        bank_q      <= bank;
                        index       <= '0;
                        err_index_q <= '0;
                        rom_addr_q  <= {bank, {ADDR_W{1'b0}}};
                    end
                end
                DECODE: begin
                    entry_q   <= rom_data;
                    retry     <= '0;
                    delay_cnt <= CNT_W'(DELAY_CYCLES - 1);
                end
                WAIT_ACK: begin
                    if (sccb.wr_nack) begin
                        if (retry == RETRY_W'(MAX_RETRY)) err_index_q <= index;
                        else                              retry <= retry + RETRY_W'(1);
                    end
                end
                DELAY: begin
                    if (delay_cnt != '0) delay_cnt <= delay_cnt - CNT_W'(1);
                end
                ADVANCE: begin
                    // Address is set up here so rom_addr only moves toward a fetch.
                    if (index != '1) begin
                        index      <= index_inc;
                        rom_addr_q <= {bank_q, index_inc};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ov7670_cfg_sequencer
//
// Scoreboard bench for ov7670_cfg_sequencer. A reference model walks the ROM
// table and queues the expected fetch addresses, writes and slave responses.
// Monitors compare the DUT's fetches and accepted writes against those queues.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ov7670_cfg_sequencer;

    localparam int ADDR_W       = 8;
    localparam int BANK_W       = 2;
    localparam int DATA_W       = 16;
    localparam int DELAY_CYCLES = 8;
    localparam int MAX_RETRY    = 3;
    localparam int AW           = BANK_W + ADDR_W;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [BANK_W-1:0] bank  = '0;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              busy, done, error;
    logic [ADDR_W-1:0] err_index;

    ov7670_cfg_sequencer_if #(.REG_W(DATA_W/2)) sccb ();

    ov7670_cfg_sequencer #(
        .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W),
        .END_CODE(16'hFFFF), .DELAY_CODE(16'hFFF0),
        .DELAY_CYCLES(DELAY_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bank(bank),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb(sccb),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    always #5 clk = ~clk;

    // Registered config ROM.
    logic [15:0] rom [0:1023];
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard state.
    logic [15:0]   wr_q[$];
    logic [AW-1:0] fetch_q[$];
    bit            resp_q[$];
    int            acc_times[$];
    int            nack_plan [0:255];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            xfer_cnt = 0;
    int            fetch_cnt = 0;
    int            x_base = 0;
    int            f_base = 0;

    // Model results for the current sequence.
    bit            exp_done, exp_error;
    logic [7:0]    exp_err_index;
    int            exp_n_writes, exp_n_fetch;

    // Slave behaviour knobs.
    int            stall_pct = 0;
    int            ack_lo = 0;
    int            ack_hi = 0;
    bit            force_ready_low = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: walk the bank from index 0 following the table rules.
    task automatic model_sequence(input logic [BANK_W-1:0] b);
        logic [15:0]   e;
        logic [AW-1:0] a;
        exp_done = 1'b0; exp_error = 1'b0; exp_err_index = '0;
        exp_n_writes = 0; exp_n_fetch = 0;
        for (int idx = 0; idx < 256; idx++) begin
            a = {b, idx[7:0]};
            e = rom[a];
            fetch_q.push_back(a);
            exp_n_fetch++;
            if (e == 16'hFFFF) begin
                exp_done = 1'b1;
                return;
            end
            if (e != 16'hFFF0) begin
                for (int k = 0; k <= MAX_RETRY; k++) begin
                    wr_q.push_back(e);
                    exp_n_writes++;
                    resp_q.push_back(k < nack_plan[idx]);
                    if (k >= nack_plan[idx]) break;
                end
                if (nack_plan[idx] > MAX_RETRY) begin
                    exp_error = 1'b1;
                    exp_err_index = idx[7:0];
                    return;
                end
            end
        end
        exp_done = 1'b1;
    endtask

    // Write monitor: a transfer happens at the next edge when valid & ready.
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        if (rst_n && sccb.wr_valid && sccb.wr_ready) begin
            xfer_cnt++;
            acc_times.push_back(cycle);
            check("write_expected", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                check("wr_reg", sccb.wr_reg, e[15:8]);
                check("wr_val", sccb.wr_val, e[7:0]);
            end
        end
    end

    // Fetch monitor.
    initial forever begin
        logic [AW-1:0] a;
        @(negedge clk);
        if (rst_n && rom_en) begin
            fetch_cnt++;
            check("fetch_expected", 32'(fetch_q.size() != 0), 1);
            if (fetch_q.size() != 0) begin
                a = fetch_q.pop_front();
                check("rom_addr", rom_addr, a);
            end
        end
    end

    // SCCB slave: random ready stalls, done/nack from the response queue.
    initial begin
        bit nk;
        sccb.wr_ready = 1'b0;
        sccb.wr_done  = 1'b0;
        sccb.wr_nack  = 1'b0;
        forever begin
            @(posedge clk); #1;
            sccb.wr_done  = 1'b0;
            sccb.wr_nack  = 1'b0;
            sccb.wr_ready = !force_ready_low && rst_n && ($urandom_range(99) >= stall_pct);
            if (sccb.wr_valid && sccb.wr_ready) begin
                nk = (resp_q.size() != 0) ? resp_q.pop_front() : 1'b0;
                @(posedge clk); #1;
                sccb.wr_ready = 1'b0;
                repeat ($urandom_range(ack_hi, ack_lo)) begin
                    @(posedge clk); #1;
                end
                sccb.wr_done = !nk;
                sccb.wr_nack = nk;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_nacks();
        for (int i = 0; i < 256; i++) nack_plan[i] = 0;
    endtask

    task automatic launch_seq(input logic [BANK_W-1:0] b);
        model_sequence(b);
        x_base = xfer_cnt;
        f_base = fetch_cnt;
        tick();
        bank  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_seq(input string tag);
        int n = 0;
        int f_end;
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_terminated"}, busy, 0);
        f_end = fetch_cnt;
        repeat (10) tick();
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, exp_error);
        check({tag, "_err_index"}, err_index, exp_err_index);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_write_count"}, xfer_cnt - x_base, exp_n_writes);
        check({tag, "_fetch_count"}, fetch_cnt - f_base, exp_n_fetch);
        check({tag, "_no_fetch_after_end"}, fetch_cnt - f_end, 0);
        check({tag, "_writes_left"}, wr_q.size(), 0);
        check({tag, "_fetches_left"}, fetch_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] hi;

        clear_nacks();

        // Reset state.
        #12;
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_wr_valid", sccb.wr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_index", err_index, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write, delay, write, end with immediate ready/done.
        rom[10'h000] = 16'h1280;
        rom[10'h001] = 16'hFFF0;
        rom[10'h002] = 16'h1204;
        rom[10'h003] = 16'hFFFF;
        acc_times.delete();
        launch_seq(2'd0);
        finish_seq("t1");
        check("t1_accepts", acc_times.size(), 2);
        // Between the two accepts: WAIT_ACK, ADVANCE, FETCH, DECODE, the
        // delay itself, ADVANCE, FETCH, DECODE, then the next ISSUE.
        if (acc_times.size() >= 2)
            check("t1_delay_gap", acc_times[1] - acc_times[0], DELAY_CYCLES + 8);

        // wr_ready held low while a request is pending.
        rom[10'h100] = 16'h3344;
        rom[10'h101] = 16'hFFFF;
        force_ready_low = 1'b1;
        launch_seq(2'd1);
        n = 0;
        while (!sccb.wr_valid && n < 100) begin
            tick();
            n++;
        end
        check("t2_valid_seen", sccb.wr_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_valid_held", sccb.wr_valid, 1);
            check("t2_reg_stable", sccb.wr_reg, 8'h33);
            check("t2_val_stable", sccb.wr_val, 8'h44);
        end
        force_ready_low = 1'b0;
        finish_seq("t2");

        // Entry 2 nacked MAX_RETRY times then acknowledged, then one more nack.
        rom[10'h000] = 16'h1111;
        rom[10'h001] = 16'h2222;
        rom[10'h002] = 16'h3333;
        rom[10'h003] = 16'hFFFF;
        nack_plan[2] = 3;
        launch_seq(2'd0);
        finish_seq("t3a");
        nack_plan[2] = 4;
        launch_seq(2'd0);
        finish_seq("t3b");
        check("t3b_err_index_2", err_index, 2);
        clear_nacks();

        // Bank 2, with a start pulse while busy that must be ignored.
        rom[10'h200] = 16'h0C00;
        rom[10'h201] = 16'hFFFF;
        launch_seq(2'd2);
        tick();
        bank  = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        bank  = 2'd2;
        finish_seq("t4");

        // Full bank of writes, no END_CODE: ends after index 255, no wrap.
        for (int i = 0; i < 256; i++) begin
            hi = 8'($urandom_range(254));
            rom[{2'd3, i[7:0]}] = {hi, 8'($urandom_range(255))};
        end
        stall_pct = 30;
        ack_lo = 0;
        ack_hi = 2;
        launch_seq(2'd3);
        finish_seq("t5");
        check("t5_last_addr", rom_addr, 10'h3FF);
        stall_pct = 0;
        ack_hi = 0;

        // Reset while waiting for the acknowledge, then restart.
        rom[10'h100] = 16'h5566;
        rom[10'h101] = 16'h7788;
        rom[10'h102] = 16'hFFFF;
        ack_lo = 10;
        ack_hi = 10;
        launch_seq(2'd1);
        n = 0;
        while (xfer_cnt == x_base && n < 200) begin
            tick();
            n++;
        end
        check("t6_first_accept", xfer_cnt - x_base, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_valid", sccb.wr_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_error", error, 0);
        check("t6_rst_err_index", err_index, 0);
        check("t6_rst_rom_en", rom_en, 0);
        check("t6_rst_rom_addr", rom_addr, 0);
        repeat (20) tick();
        wr_q.delete();
        fetch_q.delete();
        resp_q.delete();
        ack_lo = 0;
        ack_hi = 0;
        @(negedge clk);
        rst_n = 1'b1;
        launch_seq(2'd1);
        finish_seq("t6");

        // Randomised tables, nacks, stalls and acknowledge latency.
        for (int t = 0; t < 6; t++) begin
            logic [BANK_W-1:0] rb;
            int len;
            rb  = BANK_W'($urandom_range(3));
            len = $urandom_range(10, 1);
            clear_nacks();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(9) == 0) begin
                    rom[{rb, i[7:0]}] = 16'hFFF0;
                end else begin
                    hi = 8'($urandom_range(254));
                    rom[{rb, i[7:0]}] = {hi, 8'($urandom_range(255))};
                    if ($urandom_range(5) == 0) nack_plan[i] = $urandom_range(4, 1);
                end
            end
            rom[{rb, len[7:0]}] = 16'hFFFF;
            stall_pct = $urandom_range(50);
            ack_hi    = $urandom_range(3);
            launch_seq(rb);
            finish_seq("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
